// File: rtl/lookup_type_pipe_if.sv
// Lookup request/result bundle for lookup_type_pipe.
// Optional macro: LOOKUP_TYPE_MULTI_HIT_EN adds o_multi_hit.
// Handshake: i_type_valid qualifies i_type for exactly one cycle; there is no
// ready (no backpressure). o_result_valid pulses once per accepted request,
// two cycles later, and the o_* result signals hold between pulses.
interface lookup_type_pipe_if #(
  parameter int RULE_NUM         = 16,
  parameter int TYPE_NUM         = 4,
  parameter int TYPE_WIDTH       = 16,
  parameter int KEY_FIELD_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 6,
  parameter int IDX_W            = $clog2(RULE_NUM)
);
  logic                                      i_type_valid;
  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_type;
  logic                                      o_result_valid;
  logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] o_result;
  logic                                      o_hit;
  logic [IDX_W-1:0]                          o_hit_idx;
`ifdef LOOKUP_TYPE_MULTI_HIT_EN
  logic                                      o_multi_hit;

  modport master (output i_type_valid, i_type,
                  input  o_result_valid, o_result, o_hit, o_hit_idx, o_multi_hit);
  modport slave  (input  i_type_valid, i_type,
                  output o_result_valid, o_result, o_hit, o_hit_idx, o_multi_hit);
`else
  modport master (output i_type_valid, i_type,
                  input  o_result_valid, o_result, o_hit, o_hit_idx);
  modport slave  (input  i_type_valid, i_type,
                  output o_result_valid, o_result, o_hit, o_hit_idx);
`endif
endinterface

// File: rtl/lookup_type_pipe.sv
// Two-stage ternary type lookup: stage 1 matches all rules, stage 2 picks the
// lowest-index hit (or the default) and bumps per-rule / miss counters.
// Optional macro: LOOKUP_TYPE_MULTI_HIT_EN adds o_multi_hit on the interface.
module lookup_type_pipe #(
  parameter int RULE_NUM         = 16,
  parameter int TYPE_NUM         = 4,
  parameter int TYPE_WIDTH       = 16,
  parameter int KEY_FIELD_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 6,
  parameter int CNT_WIDTH        = 32,
  parameter int IDX_W            = $clog2(RULE_NUM),
  parameter int CNT_AW           = $clog2(RULE_NUM+1)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  lookup_type_pipe_if.slave                         lk,
  input  logic                                      i_cfg_wren,
  input  logic [IDX_W-1:0]                          i_cfg_addr,
  input  logic                                      i_cfg_valid,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_cfg_type_data,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_cfg_type_mask,
  input  logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] i_cfg_key_offset,
  input  logic                                      i_cfg_default_wren,
  input  logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] i_cfg_default,
  input  logic                                      i_cnt_rden,
  input  logic [CNT_AW-1:0]                         i_cnt_addr,
  input  logic                                      i_cnt_clr,
  output logic                                      o_cnt_valid,
  output logic [CNT_WIDTH-1:0]                      o_cnt_data
);
  localparam int TW = TYPE_NUM*TYPE_WIDTH;
  localparam int KW = KEY_FIELD_NUM*KEY_OFFSET_WIDTH;

  // Rule table; only the valid bits and default need a reset value.
  logic [RULE_NUM-1:0] rule_valid_q;
  logic [TW-1:0]       rule_data_q [RULE_NUM];
  logic [TW-1:0]       rule_mask_q [RULE_NUM];
  logic [KW-1:0]       rule_off_q  [RULE_NUM];
  logic [KW-1:0]       default_q;
  logic                cfg_we;

  // Stage 1 carries a snapshot of anything a same-cycle write could change,
  // so a request always resolves against the table as it was when issued.
  logic                s1_valid_q;
  logic [RULE_NUM-1:0] s1_hit_d, s1_hit_q;
  logic [KW-1:0]       s1_default_q;
  logic                s1_wr_q;
  logic [IDX_W-1:0]    s1_wr_addr_q;
  logic [KW-1:0]       s1_old_off_q;

  logic                win_any;
  logic [IDX_W-1:0]    win_idx;
  logic                multi;
  logic [KW-1:0]       win_off;

  logic                res_valid_q;
  logic [KW-1:0]       result_q;
  logic                hit_q;
  logic [IDX_W-1:0]    hit_idx_q;
  logic                multi_q;

  logic [CNT_WIDTH-1:0] cnt_q [RULE_NUM+1];
  logic [CNT_WIDTH-1:0] cnt_d [RULE_NUM+1];
  logic [CNT_AW-1:0]    inc_idx;
  logic                 rd_in_range;

  assign cfg_we      = i_cfg_wren && (32'(i_cfg_addr) < RULE_NUM);
  assign rd_in_range = 32'(i_cnt_addr) <= RULE_NUM;

  // Rule payload storage (no reset needed).
  always_ff @(posedge i_clk) begin
    if (cfg_we) begin
      rule_data_q[i_cfg_addr] <= i_cfg_type_data;
      rule_mask_q[i_cfg_addr] <= i_cfg_type_mask;
      rule_off_q[i_cfg_addr]  <= i_cfg_key_offset;
    end
  end

  // Rule valid bits and default result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rule_valid_q <= '0;
      default_q    <= '0;
    end else begin
      if (cfg_we) rule_valid_q[i_cfg_addr] <= i_cfg_valid;
      if (i_cfg_default_wren) default_q <= i_cfg_default;
    end
  end

  // Ternary match of every rule against the incoming type fields.
  always_comb begin
    s1_hit_d = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      s1_hit_d[i] = rule_valid_q[i];
      for (int j = 0; j < TYPE_NUM; j++) begin
        if ((lk.i_type[j*TYPE_WIDTH +: TYPE_WIDTH] & rule_mask_q[i][j*TYPE_WIDTH +: TYPE_WIDTH]) !=
            (rule_data_q[i][j*TYPE_WIDTH +: TYPE_WIDTH] & rule_mask_q[i][j*TYPE_WIDTH +: TYPE_WIDTH]))
          s1_hit_d[i] = 1'b0;
      end
    end
  end

  // Stage 1 register: hit vector plus table snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_hit_q     <= '0;
      s1_default_q <= '0;
      s1_wr_q      <= 1'b0;
      s1_wr_addr_q <= '0;
      s1_old_off_q <= '0;
    end else begin
      s1_valid_q   <= lk.i_type_valid;
      s1_hit_q     <= s1_hit_d;
      s1_default_q <= default_q;
      s1_wr_q      <= cfg_we;
      s1_wr_addr_q <= i_cfg_addr;
      s1_old_off_q <= rule_off_q[i_cfg_addr];
    end
  end

  // Priority encode (lowest index wins) and select the offsets.
  always_comb begin
    win_any = |s1_hit_q;
    win_idx = '0;
    for (int i = RULE_NUM-1; i >= 0; i--) begin
      if (s1_hit_q[i]) win_idx = IDX_W'(i);
    end
    multi = (s1_hit_q & (s1_hit_q - RULE_NUM'(1))) != '0;
    if (!win_any)                               win_off = s1_default_q;
    else if (s1_wr_q && s1_wr_addr_q == win_idx) win_off = s1_old_off_q;
    else                                        win_off = rule_off_q[win_idx];
  end

  // Stage 2 register: result outputs, held between requests.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      res_valid_q <= 1'b0;
      result_q    <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      multi_q     <= 1'b0;
    end else begin
      res_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q  <= win_off;
        hit_q     <= win_any;
        hit_idx_q <= win_idx;
        multi_q   <= multi;
      end
    end
  end

  assign lk.o_result_valid = res_valid_q;
  assign lk.o_result       = result_q;
  assign lk.o_hit          = hit_q;
  assign lk.o_hit_idx      = hit_idx_q;
`ifdef LOOKUP_TYPE_MULTI_HIT_EN
  assign lk.o_multi_hit    = multi_q;
`else
  logic unused_multi;
  assign unused_multi = multi_q;
`endif

  // Counter next-state: saturating increment, clear-on-read wins but keeps
  // a coincident increment (counter restarts at 1).
  always_comb begin
    inc_idx = win_any ? CNT_AW'(win_idx) : CNT_AW'(RULE_NUM);
    for (int k = 0; k <= RULE_NUM; k++) begin
      cnt_d[k] = cnt_q[k];
      if (i_cnt_rden && i_cnt_clr && rd_in_range && i_cnt_addr == CNT_AW'(k))
        cnt_d[k] = (s1_valid_q && inc_idx == CNT_AW'(k)) ? CNT_WIDTH'(1) : '0;
      else if (s1_valid_q && inc_idx == CNT_AW'(k) && cnt_q[k] != '1)
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
    end
  end

  // Counter state and registered read port.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= RULE_NUM; k++) cnt_q[k] <= '0;
      o_cnt_valid <= 1'b0;
      o_cnt_data  <= '0;
    end else begin
      for (int k = 0; k <= RULE_NUM; k++) cnt_q[k] <= cnt_d[k];
      o_cnt_valid <= i_cnt_rden;
      if (i_cnt_rden) o_cnt_data <= rd_in_range ? cnt_q[i_cnt_addr] : '0;
    end
  end
endmodule

// File: tb/tb_lookup_type_pipe.sv
// Bench for lookup_type_pipe (4-bit counters so saturation is reachable).
module tb_lookup_type_pipe;
  localparam int RN  = 16;
  localparam int TN  = 4;
  localparam int TWD = 16;
  localparam int KFN = 8;
  localparam int KOW = 6;
  localparam int CW  = 4;
  localparam int IW  = $clog2(RN);
  localparam int CAW = $clog2(RN+1);
  localparam int TW  = TN*TWD;
  localparam int KW  = KFN*KOW;
  localparam int EW  = KW+1+IW+1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lookup_type_pipe_if #(.RULE_NUM(RN), .TYPE_NUM(TN), .TYPE_WIDTH(TWD),
                        .KEY_FIELD_NUM(KFN), .KEY_OFFSET_WIDTH(KOW)) lk_if ();

  logic          cfg_wren = 1'b0, cfg_valid = 1'b0, dflt_wren = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [TW-1:0] cfg_data = '0, cfg_mask = '0;
  logic [KW-1:0] cfg_off = '0, dflt = '0;
  logic          cnt_rden = 1'b0, cnt_clr = 1'b0, cnt_valid;
  logic [CAW-1:0] cnt_addr = '0;
  logic [CW-1:0] cnt_data;

  lookup_type_pipe #(.RULE_NUM(RN), .TYPE_NUM(TN), .TYPE_WIDTH(TWD),
                     .KEY_FIELD_NUM(KFN), .KEY_OFFSET_WIDTH(KOW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .lk(lk_if),
    .i_cfg_wren(cfg_wren), .i_cfg_addr(cfg_addr), .i_cfg_valid(cfg_valid),
    .i_cfg_type_data(cfg_data), .i_cfg_type_mask(cfg_mask), .i_cfg_key_offset(cfg_off),
    .i_cfg_default_wren(dflt_wren), .i_cfg_default(dflt),
    .i_cnt_rden(cnt_rden), .i_cnt_addr(cnt_addr), .i_cnt_clr(cnt_clr),
    .o_cnt_valid(cnt_valid), .o_cnt_data(cnt_data));

  // reference model state
  logic          m_valid [RN];
  logic [TW-1:0] m_data  [RN];
  logic [TW-1:0] m_mask  [RN];
  logic [KW-1:0] m_off   [RN];
  logic [KW-1:0] m_default;
  int            m_cnt   [RN+1];

  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] cexp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RN; i++) m_valid[i] = 1'b0;
    for (int i = 0; i <= RN; i++) m_cnt[i] = 0;
    m_default = '0;
  endtask

  // first matching valid rule wins; all fields compared at once under mask
  function automatic logic [EW-1:0] model_lookup(input logic [TW-1:0] t, output int cidx);
    int n = 0;
    int first = -1;
    logic multi;
    for (int i = 0; i < RN; i++) begin
      if (m_valid[i] && ((t & m_mask[i]) == (m_data[i] & m_mask[i]))) begin
        n++;
        if (first < 0) first = i;
      end
    end
`ifdef LOOKUP_TYPE_MULTI_HIT_EN
    multi = (n > 1);
`else
    multi = 1'b0;
`endif
    cidx = (first < 0) ? RN : first;
    if (first < 0) return {m_default, 1'b0, IW'(0), multi};
    return {m_off[first], 1'b1, IW'(first), multi};
  endfunction

  // driver: one cycle with optional lookup, rule write and default write
  task automatic do_cycle(input bit lk_en, input logic [TW-1:0] t,
                          input bit wr, input int addr, input bit v,
                          input logic [TW-1:0] d, input logic [TW-1:0] m,
                          input logic [KW-1:0] off,
                          input bit dwr, input logic [KW-1:0] dval);
    int cidx;
    logic [EW-1:0] e;
    lk_if.i_type_valid = lk_en;
    lk_if.i_type = t;
    cfg_wren = wr; cfg_addr = addr[IW-1:0]; cfg_valid = v;
    cfg_data = d; cfg_mask = m; cfg_off = off;
    dflt_wren = dwr; dflt = dval;
    if (lk_en) begin
      e = model_lookup(t, cidx);
      exp_q.push_back(e);
      if (m_cnt[cidx] < (1 << CW) - 1) m_cnt[cidx]++;
    end
    if (wr && addr < RN) begin
      m_valid[addr] = v; m_data[addr] = d; m_mask[addr] = m; m_off[addr] = off;
    end
    if (dwr) m_default = dval;
    @(posedge clk); #1;
    lk_if.i_type_valid = 1'b0; cfg_wren = 1'b0; dflt_wren = 1'b0;
  endtask

  task automatic lookup(input logic [TW-1:0] t);
    do_cycle(1'b1, t, 1'b0, 0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic write_rule(input int addr, input bit v, input logic [TW-1:0] d,
                            input logic [TW-1:0] m, input logic [KW-1:0] off);
    do_cycle(1'b0, '0, 1'b1, addr, v, d, m, off, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cnt_read(input int addr, input bit clr);
    cnt_rden = 1'b1; cnt_addr = addr[CAW-1:0]; cnt_clr = clr;
    cexp_q.push_back((addr <= RN) ? CW'(m_cnt[addr]) : CW'(0));
    if (clr && addr <= RN) m_cnt[addr] = 0;
    @(posedge clk); #1;
    cnt_rden = 1'b0; cnt_clr = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic mh;
`ifdef LOOKUP_TYPE_MULTI_HIT_EN
    mh = lk_if.o_multi_hit;
`else
    mh = 1'b0;
`endif
    act = {lk_if.o_result, lk_if.o_hit, lk_if.o_hit_idx, mh};
    if (lk_if.o_result_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result", 64'(act), 64'hDEAD);
      else chk("result", 64'(act), 64'(exp_q.pop_front()));
    end
    if (cnt_valid) begin
      if (cexp_q.size() == 0) chk("unexpected_cnt", 64'(cnt_data), 64'hDEAD);
      else chk("cnt_data", 64'(cnt_data), 64'(cexp_q.pop_front()));
    end
  end

  initial begin
    logic [TW-1:0] t, d, m, x, msk3;
    logic [KW-1:0] off14;
    int pre;

    lk_if.i_type_valid = 1'b0;
    lk_if.i_type = '0;
    for (int i = 0; i < RN; i++) begin
      m_data[i] = '0; m_mask[i] = '0; m_off[i] = '0;
    end
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(1);
    @(negedge clk);
    chk("rst_result_valid", 64'(lk_if.o_result_valid), 64'd0);
    chk("rst_result", 64'(lk_if.o_result), 64'd0);
    chk("rst_hit", 64'(lk_if.o_hit), 64'd0);
    chk("rst_hit_idx", 64'(lk_if.o_hit_idx), 64'd0);
    chk("rst_cnt_valid", 64'(cnt_valid), 64'd0);
    @(posedge clk); #1;

    // miss with no rules
    lookup(64'h0800_0006_0000_0000);
    idle(3);
    cnt_read(RN, 1'b0);

    // single rule 3 on field0, then miss returns programmed default
    off14 = {KFN{6'd14}};
    write_rule(3, 1'b1, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_FFFF, off14);
    do_cycle(1'b0, '0, 1'b0, 0, 1'b0, '0, '0, '0, 1'b1, 48'h123456789ABC);
    lookup(64'h0000_0000_0000_0800);
    lookup(64'h0000_0000_0000_86DD);

    // overlapping rules 2 and 5
    write_rule(2, 1'b1, 64'h0000_0000_1111_0000, 64'h0000_0000_FFFF_0000, 48'h0A0A0A0A0A0A);
    write_rule(5, 1'b1, '0, '0, 48'h050505050505);
    lookup(64'h0000_0000_1111_0000);
    write_rule(2, 1'b0, 64'h0000_0000_1111_0000, 64'h0000_0000_FFFF_0000, 48'h0A0A0A0A0A0A);
    lookup(64'h0000_0000_1111_0000);
    write_rule(5, 1'b0, '0, '0, '0);

    // 10 back-to-back hits on rule 1, then clear-on-read racing a hit
    write_rule(1, 1'b1, 64'h0000_ABCD_0000_0000, 64'h0000_FFFF_0000_0000, 48'h111111111111);
    for (int i = 0; i < 10; i++) lookup(64'h0000_ABCD_0000_0000);
    idle(3);
    cnt_read(1, 1'b0);
    pre = m_cnt[1];
    lookup(64'h0000_ABCD_0000_0000);
    cnt_rden = 1'b1; cnt_addr = CAW'(1); cnt_clr = 1'b1;
    cexp_q.push_back(CW'(pre));
    m_cnt[1] = 1;
    @(posedge clk); #1;
    cnt_rden = 1'b0; cnt_clr = 1'b0;
    idle(3);
    cnt_read(1, 1'b0);

    // rule 0 rewritten in the same cycle as a lookup
    x = 64'h5A5A_0000_0000_0000;
    msk3 = 64'hFFFF_0000_0000_0000;
    do_cycle(1'b1, x, 1'b1, 0, 1'b1, x, msk3, 48'h3F3F3F3F3F3F, 1'b0, '0);
    lookup(x);

    // saturation of rule 3 counter
    idle(3);
    cnt_read(3, 1'b1);
    for (int i = 0; i < 20; i++) lookup(64'h0000_0000_0000_0800);
    idle(3);
    cnt_read(3, 1'b0);

    // randomized traffic with concurrent rule and default writes
    for (int n = 0; n < 300; n++) begin
      bit lk_en, wr, dwr;
      int a, r;
      lk_en = ($urandom_range(0, 9) < 8);
      wr = ($urandom_range(0, 4) == 0);
      dwr = ($urandom_range(0, 19) == 0);
      a = $urandom_range(0, RN-1);
      for (int j = 0; j < TN; j++) begin
        d[j*TWD +: TWD] = 16'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: m[j*TWD +: TWD] = 16'h0000;
          3: m[j*TWD +: TWD] = 16'($urandom);
          default: m[j*TWD +: TWD] = 16'hFFFF;
        endcase
      end
      r = $urandom_range(0, RN-1);
      t = m_data[r];
      if ($urandom_range(0, 2) == 0) begin
        int f;
        f = $urandom_range(0, TN-1);
        t[f*TWD +: TWD] = 16'($urandom_range(0, 3));
      end
      do_cycle(lk_en, t, wr, a, ($urandom_range(0, 5) != 0), d, m,
               KW'({$urandom, $urandom}), dwr, KW'({$urandom, $urandom}));
    end
    idle(3);
    for (int a = 0; a <= RN; a++) cnt_read(a, 1'b0);
    cnt_read($urandom_range(RN+1, (1 << CAW) - 1), 1'b0);

    // reset with two lookups in flight
    idle(3);
    lookup(64'h0000_0000_0000_0800);
    lk_if.i_type_valid = 1'b1;
    lk_if.i_type = 64'h0000_0000_0000_0800;
    rst_n = 1'b0;
    @(posedge clk); #1;
    lk_if.i_type_valid = 1'b0;
    exp_q.delete();
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(3);
    cnt_read(3, 1'b0);
    cnt_read(RN, 1'b0);
    lookup(64'h0000_0000_0000_0800);
    idle(5);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("cexp_q_drained", 64'(cexp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
